// File: rtl/bcd_counter_7seg_mux.sv
`timescale 1ns/1ps
// bcd_counter_7seg_mux
// N-digit BCD up/down counter with a multiplexed 7-segment display driver.
//
// Parameters:
//   CLK_HZ, COUNT_HZ, SCAN_HZ : clock, count-tick and digit-step rates.
//                               CLK_HZ/COUNT_HZ and CLK_HZ/SCAN_HZ must be >= 2.
//   DIGITS                    : number of digits, 1..8
//   SEG_ACTIVE_LOW            : 1 = segment lit when its output bit is 0
//   DIG_ACTIVE_LOW            : 1 = digit enabled when its output bit is 0
//
// Ports:
//   clk, rst_n   : clock; asynchronous active-low reset, release synchronised
//   en           : count enable (also gates the count prescaler)
//   up           : 1 = count up, 0 = count down
//   clr          : synchronous clear of count and count prescaler
//   blank_lz     : leading-zero blanking enable
//   dp_mask      : per-digit decimal point, bit i = digit i
//   seg          : registered segment drive {dp,g,f,e,d,c,b,a}
//   digit        : registered one-hot digit enable, bit 0 = units
//   value        : BCD count, nibble i = digit i
//   wrap         : one-cycle pulse on all-nines/all-zero wrap-around
//
// rst_n release passes through a two-flop synchroniser; all cycle counts
// (first scan step after SCAN_DIV cycles, first tick after CNT_DIV cycles)
// are measured from the internal release, two clk edges after rst_n rises.
module bcd_counter_7seg_mux #(
  parameter int unsigned CLK_HZ         = 12_000_000,
  parameter int unsigned COUNT_HZ       = 1,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DIGITS         = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     digit,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap
);

  localparam int unsigned CNT_DIV  = CLK_HZ / COUNT_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W    = $clog2(CNT_DIV);
  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
  localparam int unsigned P_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  // Active-low a..g pattern for one BCD digit; out-of-range codes show nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Reset synchroniser: asserts immediately, releases after two edges.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Count prescaler, frozen while en=0.
  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;

  assign tick_c = en && (cnt_q == CNT_W'(CNT_DIV - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)  cnt_q <= '0;
    else if (clr)    cnt_q <= '0;
    else if (tick_c) cnt_q <= '0;
    else if (en)     cnt_q <= cnt_q + CNT_W'(1);
  end

  // Ripple carry/borrow across BCD digits; carry out of the top digit is wrap.
  logic [DIGITS-1:0][3:0] value_q;
  logic [DIGITS-1:0][3:0] val_step_c;
  logic                   carry_c;

  always_comb begin
    val_step_c = value_q;
    carry_c    = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry_c) begin
        if (up) begin
          if (value_q[i] == 4'd9) begin
            val_step_c[i] = 4'd0;
          end else begin
            val_step_c[i] = value_q[i] + 4'd1;
            carry_c       = 1'b0;
          end
        end else begin
          if (value_q[i] == 4'd0) begin
            val_step_c[i] = 4'd9;
          end else begin
            val_step_c[i] = value_q[i] - 4'd1;
            carry_c       = 1'b0;
          end
        end
      end
    end
  end

  // Count register; clr wins over a coincident tick.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      value_q <= '0;
      wrap    <= 1'b0;
    end else if (clr) begin
      value_q <= '0;
      wrap    <= 1'b0;
    end else if (tick_c) begin
      value_q <= val_step_c;
      wrap    <= carry_c;
    end else begin
      wrap    <= 1'b0;
    end
  end

  assign value = value_q;

  // Free-running scan prescaler.
  logic [SCAN_W-1:0] scan_q;
  logic              step_c;

  assign step_c = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)  scan_q <= '0;
    else if (step_c) scan_q <= '0;
    else             scan_q <= scan_q + SCAN_W'(1);
  end

  // Next scan position; reset parks at the top digit so the first step shows 0.
  logic [P_W-1:0] p_q;
  logic [P_W-1:0] p_next_c;

  assign p_next_c = (p_q == P_W'(DIGITS - 1)) ? '0 : p_q + P_W'(1);

  // lz_c[i] = nibbles i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] lz_c;
  logic              zero_run_c;

  always_comb begin
    lz_c       = '0;
    zero_run_c = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (value_q[i] == 4'd0);
      lz_c[i]    = zero_run_c;
    end
  end

  // Display word for the digit about to be selected.
  logic              blank_c;
  logic [7:0]        seg_al_c;
  logic [DIGITS-1:0] dig_hot_c;

  always_comb begin
    blank_c   = blank_lz && (p_next_c != '0) && lz_c[p_next_c];
    seg_al_c  = {~dp_mask[p_next_c], blank_c ? 7'h7F : seg_decode(value_q[p_next_c])};
    dig_hot_c = DIGITS'(1) << p_next_c;
  end

  // seg and digit load on the same edge so they never skew.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      p_q   <= P_W'(DIGITS - 1);
      seg   <= SEG_OFF;
      digit <= DIG_OFF;
    end else if (step_c) begin
      p_q   <= p_next_c;
      seg   <= SEG_ACTIVE_LOW ? seg_al_c  : ~seg_al_c;
      digit <= DIG_ACTIVE_LOW ? ~dig_hot_c : dig_hot_c;
    end
  end

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
`timescale 1ns/1ps
// Directed bench for bcd_counter_7seg_mux: CNT_DIV=10, SCAN_DIV=2, 4 digits,
// active-low segments and digits. Inputs change and outputs are sampled on
// the falling clock edge; "edge k" below is the k-th rising edge after the
// internal (synchronised) reset release.
module tb_bcd_counter_7seg_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clr;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [7:0]  seg;
  logic [3:0]  digit;
  logic [15:0] value;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_counter_7seg_mux #(
    .CLK_HZ(100), .COUNT_HZ(10), .SCAN_HZ(50), .DIGITS(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr),
    .blank_lz(blank_lz), .dp_mask(dp_mask),
    .seg(seg), .digit(digit), .value(value), .wrap(wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for value to reach target; a timeout shows up as a failed check.
  task automatic wait_value(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (value !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(value), 32'(target));
  endtask

  task automatic wait_digit(input string tag, input logic [3:0] target, input int budget);
    int n = 0;
    while (digit !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(digit), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
    blank_lz = 1'b0; dp_mask = 4'b0000;

    // Reset state
    cycles(3);
    check("rst_seg",   32'(seg),   32'hFF);
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_value", 32'(value), 32'h0000);
    check("rst_wrap",  32'(wrap),  32'h0);

    // Release and let the synchroniser settle (two edges)
    rst_n = 1'b1;
    cycles(2);
    check("sync_seg",   32'(seg),   32'hFF);
    check("sync_digit", 32'(digit), 32'hF);

    cycles(1); // edge 1
    check("e1_seg",   32'(seg),   32'hFF);
    check("e1_digit", 32'(digit), 32'hF);
    cycles(1); // edge 2: first scan step, slot 0 shows '0'
    check("e2_digit", 32'(digit), 32'hE);
    check("e2_seg",   32'(seg),   32'hC0);
    cycles(1); // edge 3: slot held
    check("e3_digit", 32'(digit), 32'hE);
    cycles(6); // edge 9
    check("e9_value", 32'(value), 32'h0000);
    cycles(1); // edge 10: first tick
    check("e10_value", 32'(value), 32'h0001);
    check("e10_wrap",  32'(wrap),  32'h0);

    // Carry chain on the way up
    wait_value("reach_0009", 16'h0009, 200);
    cycles(10);
    check("carry_0010", 32'(value), 32'h0010);
    wait_value("reach_0099", 16'h0099, 1200);
    cycles(10);
    check("carry_0100", 32'(value), 32'h0100);
    wait_value("reach_0999", 16'h0999, 12000);
    cycles(10);
    check("carry_1000", 32'(value), 32'h1000);
    check("carry_wrap", 32'(wrap),  32'h0);

    // Clear, then count down through the wrap
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_value", 32'(value), 32'h0000);
    up = 1'b0;
    cycles(9);
    check("dn_pre_value", 32'(value), 32'h0000);
    cycles(1);
    check("dn_wrap_value", 32'(value), 32'h9999);
    check("dn_wrap_pulse", 32'(wrap),  32'h1);
    cycles(1);
    check("dn_wrap_1cyc", 32'(wrap), 32'h0);
    cycles(9);
    check("dn_9998",      32'(value), 32'h9998);
    check("dn_9998_wrap", 32'(wrap),  32'h0);

    // Up through the wrap
    up = 1'b1;
    cycles(10);
    check("up_9999",      32'(value), 32'h9999);
    check("up_9999_wrap", 32'(wrap),  32'h0);
    cycles(10);
    check("up_wrap_value", 32'(value), 32'h0000);
    check("up_wrap_pulse", 32'(wrap),  32'h1);
    cycles(1);
    check("up_wrap_1cyc", 32'(wrap), 32'h0);

    // Back to 9999, then clr on the very tick that would wrap
    up = 1'b0;
    cycles(9);
    check("pri_9999", 32'(value), 32'h9999);
    up = 1'b1;
    cycles(9);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("pri_value", 32'(value), 32'h0000);
    check("pri_wrap",  32'(wrap),  32'h0);

    // Freeze the prescaler mid-period for 37 cycles
    cycles(10);
    check("frz_0001", 32'(value), 32'h0001);
    cycles(4);
    en = 1'b0;
    cycles(37);
    check("frz_hold", 32'(value), 32'h0001);
    en = 1'b1;
    cycles(5);
    check("frz_no_early", 32'(value), 32'h0001);
    cycles(1);
    check("frz_late_tick", 32'(value), 32'h0002);

    // Leading-zero blanking and decimal point on 0007
    wait_value("reach_0007", 16'h0007, 100);
    en = 1'b0;
    blank_lz = 1'b1;
    dp_mask = 4'b0010;
    cycles(8);
    wait_digit("lz_sync0", 4'hE, 10);
    check("lz_slot0", 32'(seg), 32'hF8);
    cycles(2);
    check("lz_dig1",  32'(digit), 32'hD);
    check("lz_slot1", 32'(seg),   32'h7F);
    cycles(2);
    check("lz_dig2",  32'(digit), 32'hB);
    check("lz_slot2", 32'(seg),   32'hFF);
    cycles(2);
    check("lz_dig3",  32'(digit), 32'h7);
    check("lz_slot3", 32'(seg),   32'hFF);

    blank_lz = 1'b0;
    cycles(8);
    wait_digit("nb_sync0", 4'hE, 10);
    check("nb_slot0", 32'(seg), 32'hF8);
    cycles(2);
    check("nb_slot1", 32'(seg), 32'h40);
    cycles(2);
    check("nb_slot2", 32'(seg), 32'hC0);
    cycles(2);
    check("nb_slot3", 32'(seg), 32'hC0);

    // Asynchronous reset mid-slot, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg",   32'(seg),   32'hFF);
    check("arst_digit", 32'(digit), 32'hF);
    check("arst_value", 32'(value), 32'h0000);
    check("arst_wrap",  32'(wrap),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
